// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its FPU scoreboard.
package hazard_ctrl_pkg;

    localparam int REG_W = 6;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_E   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_e;

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register countdown of outstanding multi-cycle FPU results, with two busy lookups for decode.
module fpu_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 64,
    parameter int LATW = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fpu_issue,
    input  logic [REG_W-1:0] fpu_rd,
    input  logic [LATW-1:0]  fpu_lat,
    input  logic [REG_W-1:0] rd_addr0,
    input  logic [REG_W-1:0] rd_addr1,
    output logic             busy0,
    output logic             busy1
);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];

    // A fresh issue overwrites whatever is still counting for that register.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (fpu_issue && fpu_rd == REG_W'(i)) begin
                cnt_d[i] = fpu_lat;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - LATW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy0 = (cnt_q[rd_addr0] != '0);
    assign busy1 = (cnt_q[rd_addr1] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: operand forwarding, load-use and FPU-latency stalls, mispredict flushes.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 64,
    parameter int LATW = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs0,
    input  logic [REG_W-1:0] d_rs1,
    input  logic             d_use0,
    input  logic             d_use1,
    input  logic             e_valid,
    input  logic             e_regwrite,
    input  logic             e_memread,
    input  logic [REG_W-1:0] e_rd,
    input  logic             m_valid,
    input  logic             m_regwrite,
    input  logic [REG_W-1:0] m_rd,
    input  logic             fpu_issue,
    input  logic [REG_W-1:0] fpu_rd,
    input  logic [LATW-1:0]  fpu_lat,
    input  logic             mispredict,
    output logic [1:0]       forward0,
    output logic [1:0]       forward1,
    output logic             stall_fd,
    output logic             flush_de,
    output logic             flush_fd,
    output logic [31:0]      stall_cycles
);

    logic      rel0, rel1, busy0, busy1, load_use0, load_use1, stall_cond;
    logic      e_fwd_ok, m_fwd_ok;
    fwd_sel_e  fwd0, fwd1;
    hz_state_e state_q, state_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    fpu_scoreboard #(
        .NREG (NREG),
        .LATW (LATW)
    ) u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .fpu_issue (fpu_issue),
        .fpu_rd    (fpu_rd),
        .fpu_lat   (fpu_lat),
        .rd_addr0  (d_rs0),
        .rd_addr1  (d_rs1),
        .busy0     (busy0),
        .busy1     (busy1)
    );

    // Only the integer r0 is hardwired; float register 32 is an ordinary register.
    assign rel0 = d_valid && d_use0 && (d_rs0 != REG_ZERO);
    assign rel1 = d_valid && d_use1 && (d_rs1 != REG_ZERO);

    assign e_fwd_ok  = e_valid && e_regwrite && !e_memread;
    assign m_fwd_ok  = m_valid && m_regwrite;
    assign load_use0 = e_valid && e_memread && (e_rd == d_rs0);
    assign load_use1 = e_valid && e_memread && (e_rd == d_rs1);

    assign stall_cond = (rel0 && (load_use0 || busy0)) || (rel1 && (load_use1 || busy1));

    always_comb begin
        fwd0 = FWD_REG;
        fwd1 = FWD_REG;
        if (rel0 && e_fwd_ok && e_rd == d_rs0) begin
            fwd0 = FWD_E;
        end else if (rel0 && m_fwd_ok && m_rd == d_rs0) begin
            fwd0 = FWD_M;
        end
        if (rel1 && e_fwd_ok && e_rd == d_rs1) begin
            fwd1 = FWD_E;
        end else if (rel1 && m_fwd_ok && m_rd == d_rs1) begin
            fwd1 = FWD_M;
        end
    end

    // A mispredict wins over any stall; the cycle after it still bubbles execute.
    always_comb begin
        state_d        = state_q;
        stall_fd       = 1'b0;
        flush_de       = 1'b0;
        flush_fd       = 1'b0;
        forward0       = FWD_REG;
        forward1       = FWD_REG;
        stall_cycles_d = stall_cycles_q;
        if (rstn) begin
            state_d = RUN;
        end else begin
            forward0 = fwd0;
            forward1 = fwd1;
            if (mispredict) begin
                flush_fd = 1'b1;
                flush_de = 1'b1;
                state_d  = FLUSH;
            end else if (state_q == FLUSH) begin
                flush_de = 1'b1;
                state_d  = RUN;
            end else begin
                stall_fd = stall_cond;
                flush_de = stall_cond;
                state_d  = stall_cond ? STALL : RUN;
            end
            stall_cycles_d = stall_cycles_q + 32'(stall_fd);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios, then random traffic against a reference model.
module tb_hazard_ctrl;

    logic        clk;
    logic        rstn;
    logic        d_valid, d_use0, d_use1;
    logic [5:0]  d_rs0, d_rs1;
    logic        e_valid, e_regwrite, e_memread;
    logic [5:0]  e_rd;
    logic        m_valid, m_regwrite;
    logic [5:0]  m_rd;
    logic        fpu_issue;
    logic [5:0]  fpu_rd;
    logic [2:0]  fpu_lat;
    logic        mispredict;
    logic [1:0]  forward0, forward1;
    logic        stall_fd, flush_de, flush_fd;
    logic [31:0] stall_cycles;

    int          numChecks = 0;
    int          numFails  = 0;

    // Reference model: remaining cycles per register, stall tally, and whether last cycle mispredicted.
    int          sbModel [64];
    bit [31:0]   stallCountModel;
    bit          flushedLast;
    bit          expStallNow;

    hazard_ctrl #(
        .NREG (64),
        .LATW (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .d_valid      (d_valid),
        .d_rs0        (d_rs0),
        .d_rs1        (d_rs1),
        .d_use0       (d_use0),
        .d_use1       (d_use1),
        .e_valid      (e_valid),
        .e_regwrite   (e_regwrite),
        .e_memread    (e_memread),
        .e_rd         (e_rd),
        .m_valid      (m_valid),
        .m_regwrite   (m_regwrite),
        .m_rd         (m_rd),
        .fpu_issue    (fpu_issue),
        .fpu_rd       (fpu_rd),
        .fpu_lat      (fpu_lat),
        .mispredict   (mispredict),
        .forward0     (forward0),
        .forward1     (forward1),
        .stall_fd     (stall_fd),
        .flush_de     (flush_de),
        .flush_fd     (flush_fd),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic bit relevant(input logic use_, input logic [5:0] rs);
        return d_valid && use_ && (rs != 6'd0);
    endfunction

    function automatic logic [1:0] expFwd(input logic use_, input logic [5:0] rs);
        if (rstn || !relevant(use_, rs)) return 2'b00;
        if (e_valid && e_regwrite && !e_memread && e_rd == rs) return 2'b01;
        if (m_valid && m_regwrite && m_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit blocked(input logic use_, input logic [5:0] rs);
        return relevant(use_, rs) && ((e_valid && e_memread && e_rd == rs) || sbModel[rs] > 0);
    endfunction

    // Compare every output against the model mid-cycle, while inputs are stable.
    task automatic evalCycle();
        bit expDe, expFd;
        @(negedge clk);
        expStallNow = 1'b0;
        expDe       = 1'b0;
        expFd       = 1'b0;
        if (!rstn) begin
            if (mispredict) begin
                expDe = 1'b1;
                expFd = 1'b1;
            end else if (flushedLast) begin
                expDe = 1'b1;
            end else begin
                expStallNow = blocked(d_use0, d_rs0) || blocked(d_use1, d_rs1);
                expDe       = expStallNow;
            end
        end
        checkOutput("forward0", 32'(forward0), 32'(expFwd(d_use0, d_rs0)));
        checkOutput("forward1", 32'(forward1), 32'(expFwd(d_use1, d_rs1)));
        checkOutput("stall_fd", 32'(stall_fd), 32'(expStallNow));
        checkOutput("flush_de", 32'(flush_de), 32'(expDe));
        checkOutput("flush_fd", 32'(flush_fd), 32'(expFd));
        checkOutput("stall_cycles", stall_cycles, stallCountModel);
    endtask

    task automatic advanceCycle();
        if (rstn) begin
            foreach (sbModel[r]) sbModel[r] = 0;
            stallCountModel = '0;
            flushedLast     = 1'b0;
        end else begin
            stallCountModel = stallCountModel + 32'(expStallNow);
            for (int r = 0; r < 64; r++) begin
                if (fpu_issue && fpu_rd == 6'(r)) sbModel[r] = int'(fpu_lat);
                else if (sbModel[r] > 0) sbModel[r] = sbModel[r] - 1;
            end
            flushedLast = mispredict;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rstn = 0; d_valid = 0; d_use0 = 0; d_use1 = 0; d_rs0 = 0; d_rs1 = 0;
        e_valid = 0; e_regwrite = 0; e_memread = 0; e_rd = 0;
        m_valid = 0; m_regwrite = 0; m_rd = 0;
        fpu_issue = 0; fpu_rd = 0; fpu_lat = 0; mispredict = 0;
    endtask

    task automatic resetCycle();
        clearInputs();
        rstn = 1;
        evalCycle();
        advanceCycle();
        rstn = 0;
    endtask

    function automatic logic [5:0] pickReg();
        case ($urandom_range(0, 7))
            0:       return 6'd0;
            1:       return 6'd3;
            2:       return 6'd5;
            3:       return 6'd7;
            4:       return 6'd32;
            5:       return 6'd40;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic applyStimulus();
        rstn       = ($urandom_range(0, 39) == 0);
        d_valid    = ($urandom_range(0, 4) != 0);
        d_use0     = 1'($urandom);
        d_use1     = 1'($urandom);
        d_rs0      = pickReg();
        d_rs1      = pickReg();
        e_valid    = 1'($urandom);
        e_regwrite = 1'($urandom);
        e_memread  = ($urandom_range(0, 3) == 0);
        e_rd       = pickReg();
        m_valid    = 1'($urandom);
        m_regwrite = 1'($urandom);
        m_rd       = pickReg();
        fpu_issue  = ($urandom_range(0, 5) == 0);
        fpu_rd     = pickReg();
        fpu_lat    = 3'($urandom_range(1, 7));
        mispredict = ($urandom_range(0, 11) == 0);
    endtask

    initial begin
        foreach (sbModel[r]) sbModel[r] = 0;
        stallCountModel = '0;
        flushedLast     = 1'b0;
        expStallNow     = 1'b0;
        clearInputs();
        rstn = 1;
        @(posedge clk);
        #1;
        resetCycle();
        checkOutput("reset_stall_cycles", stall_cycles, 32'd0);

        // Execute add to r5 feeds decode rs0 directly.
        d_valid = 1; d_use0 = 1; d_rs0 = 5;
        e_valid = 1; e_regwrite = 1; e_rd = 5;
        evalCycle();
        checkOutput("add_fwd0", 32'(forward0), 32'd1);
        checkOutput("add_nostall", 32'(stall_fd), 32'd0);
        advanceCycle();

        // Execute beats memory on r7; memory alone forwards from memory.
        clearInputs();
        d_valid = 1; d_use1 = 1; d_rs1 = 7;
        e_valid = 1; e_regwrite = 1; e_rd = 7;
        m_valid = 1; m_regwrite = 1; m_rd = 7;
        evalCycle();
        checkOutput("both_fwd1", 32'(forward1), 32'd1);
        advanceCycle();
        e_valid = 0;
        evalCycle();
        checkOutput("mem_fwd1", 32'(forward1), 32'd2);
        advanceCycle();

        // Load to r3 stalls one cycle, then the load sits in memory.
        clearInputs();
        d_valid = 1; d_use0 = 1; d_rs0 = 3;
        e_valid = 1; e_regwrite = 1; e_memread = 1; e_rd = 3;
        evalCycle();
        checkOutput("lu_stall", 32'(stall_fd), 32'd1);
        checkOutput("lu_flush_de", 32'(flush_de), 32'd1);
        advanceCycle();
        e_valid = 0; e_memread = 0;
        m_valid = 1; m_regwrite = 1; m_rd = 3;
        evalCycle();
        checkOutput("lu_release", 32'(stall_fd), 32'd0);
        checkOutput("lu_fwd0", 32'(forward0), 32'd2);
        advanceCycle();

        // Zero register never forwards or stalls.
        clearInputs();
        d_valid = 1; d_use0 = 1; d_rs0 = 0;
        e_valid = 1; e_regwrite = 1; e_rd = 0;
        evalCycle();
        checkOutput("r0_fwd0", 32'(forward0), 32'd0);
        checkOutput("r0_nostall", 32'(stall_fd), 32'd0);
        advanceCycle();

        // FPU result to r40 with latency 3 blocks decode for three cycles.
        resetCycle();
        fpu_issue = 1; fpu_rd = 40; fpu_lat = 3;
        evalCycle();
        advanceCycle();
        fpu_issue = 0;
        d_valid = 1; d_use0 = 1; d_rs0 = 40;
        for (int c = 0; c < 3; c++) begin
            evalCycle();
            checkOutput("fpu_stall", 32'(stall_fd), 32'd1);
            advanceCycle();
        end
        evalCycle();
        checkOutput("fpu_release", 32'(stall_fd), 32'd0);
        checkOutput("fpu_stall_cycles", stall_cycles, 32'd3);
        advanceCycle();

        // Mispredict in the middle of an FPU stall; the scoreboard keeps counting.
        resetCycle();
        fpu_issue = 1; fpu_rd = 40; fpu_lat = 5;
        evalCycle();
        advanceCycle();
        fpu_issue = 0;
        d_valid = 1; d_use0 = 1; d_rs0 = 40;
        evalCycle();
        checkOutput("mp_pre_stall", 32'(stall_fd), 32'd1);
        advanceCycle();
        mispredict = 1;
        evalCycle();
        checkOutput("mp_flush_fd", 32'(flush_fd), 32'd1);
        checkOutput("mp_flush_de", 32'(flush_de), 32'd1);
        checkOutput("mp_no_stall", 32'(stall_fd), 32'd0);
        advanceCycle();
        mispredict = 0;
        evalCycle();
        checkOutput("flush_de_after", 32'(flush_de), 32'd1);
        checkOutput("flush_fd_after", 32'(flush_fd), 32'd0);
        checkOutput("stall_after", 32'(stall_fd), 32'd0);
        advanceCycle();
        for (int c = 0; c < 2; c++) begin
            evalCycle();
            checkOutput("mp_resume_stall", 32'(stall_fd), 32'd1);
            advanceCycle();
        end
        evalCycle();
        checkOutput("mp_release", 32'(stall_fd), 32'd0);
        checkOutput("mp_stall_cycles", stall_cycles, 32'd3);
        advanceCycle();

        // Reset during a stall, together with issue and mispredict, clears everything.
        fpu_issue = 1; fpu_rd = 40; fpu_lat = 7;
        evalCycle();
        advanceCycle();
        fpu_issue = 0;
        evalCycle();
        advanceCycle();
        rstn = 1; fpu_issue = 1; mispredict = 1;
        evalCycle();
        checkOutput("rst_stall", 32'(stall_fd), 32'd0);
        checkOutput("rst_flush_fd", 32'(flush_fd), 32'd0);
        advanceCycle();
        rstn = 0; fpu_issue = 0; mispredict = 0;
        evalCycle();
        checkOutput("post_rst_stall", 32'(stall_fd), 32'd0);
        checkOutput("post_rst_flush_de", 32'(flush_de), 32'd0);
        checkOutput("post_rst_cycles", stall_cycles, 32'd0);
        advanceCycle();

        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            evalCycle();
            advanceCycle();
        end

        $display("[TB] random phase complete");
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 64: architectural register count (int 0-31, float 32-63).
REQ-002 SHALL have parameter LATW, default 3: width of the FPU latency field and of each scoreboard counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rstn  in  1  synchronous reset, active-high (1 = reset).
REQ-005 d_valid  in  1  decode holds a valid instruction.
REQ-006 d_rs0, d_rs1  in  6 each  decode source registers.
REQ-007 d_use0, d_use1  in  1 each  decode instruction reads rs0 / rs1.
REQ-008 e_valid, e_regwrite, e_memread  in  1 each  execute-stage status.
REQ-009 e_rd  in  6  execute-stage destination register.
REQ-010 m_valid, m_regwrite  in  1 each  memory-stage status.
REQ-011 m_rd  in  6  memory-stage destination register.
REQ-012 fpu_issue  in  1  multi-cycle FPU op leaves execute this cycle.
REQ-013 fpu_rd  in  6  destination register of that FPU op.
REQ-014 fpu_lat  in  LATW  cycles until the FPU result is in the register file (1-7).
REQ-015 mispredict  in  1  execute resolved a branch mispredict.
REQ-016 forward0, forward1  out  2 each  operand source: 00 register file, 01 execute result, 10 memory result.
REQ-017 stall_fd  out  1  hold fetch and decode.
REQ-018 flush_de  out  1  insert a bubble into execute.
REQ-019 flush_fd  out  1  invalidate the fetch and decode contents.
REQ-020 stall_cycles  out  32  performance counter.

Function
REQ-021 Operand n (0/1) SHALL be hazard-relevant only if d_valid & d_usen and d_rsn != 0; registers 32-63 SHALL have no zero exception.
REQ-022 forwardn SHALL be 01 if e_valid & e_regwrite & !e_memread & e_rd == d_rsn; else 10 if m_valid & m_regwrite & m_rd == d_rsn; else 00. Execute SHALL have priority over memory.
REQ-023 forwardn SHALL be purely combinational and 00 for any operand that is not hazard-relevant.
REQ-024 Load-use: a relevant operand with e_valid & e_memread & e_rd == d_rsn SHALL assert stall_fd and flush_de for exactly 1 cycle.
REQ-025 Scoreboard: one LATW-bit down-counter per register. fpu_issue SHALL load cnt[fpu_rd] = fpu_lat.
REQ-026 Every nonzero counter not being loaded in a cycle SHALL decrement by 1.
REQ-027 A relevant operand whose counter is nonzero SHALL assert stall_fd and flush_de.
REQ-028 If fpu_issue targets a register whose counter is already nonzero, the new value SHALL overwrite it.
REQ-029 FSM states: RUN, STALL, FLUSH.
  - RUN->STALL on any stall condition.
  - STALL->RUN once no condition remains.
  - Any state->FLUSH on mispredict.
  - FLUSH->RUN unconditionally after 1 cycle.
REQ-030 mispredict SHALL assert flush_fd and flush_de in the same cycle and SHALL force stall_fd = 0 (flush overrides stall).
REQ-031 In FLUSH, stall_fd SHALL be 0 and flush_de SHALL be 1, so the refetched slot is bubbled.
REQ-032 Scoreboard counters SHALL NOT be cleared by mispredict; an issued FPU op always retires.
REQ-033 stall_cycles SHALL increment each cycle stall_fd = 1 and SHALL wrap at 2^32-1 -> 0.

Reset
REQ-034 While rstn = 1: all counters = 0, state = RUN, stall_cycles = 0, stall_fd = flush_de = flush_fd = 0, forward0 = forward1 = 00.
REQ-035 Reset SHALL override fpu_issue and mispredict in the same cycle; a mid-stall reset SHALL release the stall the next cycle.

Structure
REQ-036 A shared package SHALL hold:
  - the forward-select enum (FWD_REG = 00, FWD_E = 01, FWD_M = 10);
  - the FSM state enum;
  - the REG_ZERO constant.
REQ-037 The scoreboard SHALL be the sub-module fpu_scoreboard (counter array plus two busy read ports); everything else stays in hazard_ctrl.

Verification
REQ-038 Execute add writes r5, decode reads r5 on rs0 -> forward0 = 01, no stall.
REQ-039 Execute and memory both write r7, decode reads r7 on rs1 -> forward1 = 01. With only memory writing r7 -> forward1 = 10.
REQ-040 Execute load to r3, decode uses r3 -> stall_fd = flush_de = 1 for 1 cycle, then forward0 = 10.
REQ-041 fpu_issue, fpu_rd = 40, fpu_lat = 3, decode reads r40 -> stall_fd high 3 cycles, low on cycle 4, stall_cycles = 3.
REQ-042 mispredict during an FPU stall -> flush_fd = flush_de = 1 and stall_fd = 0 that cycle; next cycle only flush_de = 1; r40 counter keeps counting down.
REQ-043 Decode reads r0 while execute writes r0 -> forward0 = 00, no stall.
